// File: rtl/de1_soc_demo_leds_pwm.sv
// -----------------------------------------------------------------------------
// de1_soc_demo_leds_pwm
//
// Avalon-MM PIO slave driving the DE1-SoC red LEDs (LEDR). Software controls
// an LED enable mask (with set/clear strobe registers), a global PWM
// brightness and a per-LED blink mask with a programmable blink rate.
//
// Register map (word addresses, unused upper bits read 0):
//   0 DATA         RW  LED enable mask
//   1 BRIGHT       RW  PWM duty request
//   2 OUTSET       W   DATA |= writedata  (reads 0)
//   3 OUTCLEAR     W   DATA &= ~writedata (reads 0)
//   4 BLINK        RW  blink mask
//   5 BLINK_PERIOD RW  PWM periods per blink half-phase (0 = no blinking)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word register address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data (1-cycle latency, no wait states)
//   out_port   registered LED drive
// -----------------------------------------------------------------------------
module de1_soc_demo_leds_pwm #(
    parameter int WIDTH    = 10,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BRIGHT       = 3'd1;
    localparam logic [2:0] ADDR_OUTSET       = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd3;
    localparam logic [2:0] ADDR_BLINK        = 3'd4;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0]    data_reg;
    logic [PWM_BITS-1:0] bright_reg;
    logic [PWM_BITS-1:0] duty;
    logic [WIDTH-1:0]    blink_reg;
    logic [15:0]         blink_period;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         blink_cnt;
    logic                blink_phase;

    logic                wr_en;
    logic                wr_blink_period;
    logic                tick;
    logic                period_end;
    logic                pwm_on;
    logic [31:0]         rd_mux;

    // Bits of writedata above the register widths are intentionally ignored.
    logic                unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en           = chipselect & ~write_n;
    assign wr_blink_period = wr_en && (address == ADDR_BLINK_PERIOD);

    assign tick       = (pre_cnt == PRE_LAST);
    assign period_end = tick && (pwm_cnt == DUTY_FULL);

    // Full-scale duty is special-cased so all-ones means "always on" rather
    // than missing the last PWM slot.
    assign pwm_on = (duty == DUTY_FULL) ? 1'b1 : (pwm_cnt < duty);

    // ---------------------------------------------------------------------
    // Register writes
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg     <= '0;
            bright_reg   <= DUTY_FULL;
            blink_reg    <= '0;
            blink_period <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:         data_reg     <= writedata[WIDTH-1:0];
                ADDR_BRIGHT:       bright_reg   <= writedata[PWM_BITS-1:0];
                ADDR_OUTSET:       data_reg     <= data_reg | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:     data_reg     <= data_reg & ~writedata[WIDTH-1:0];
                ADDR_BLINK:        blink_reg    <= writedata[WIDTH-1:0];
                ADDR_BLINK_PERIOD: blink_period <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Prescaler and PWM counter; duty shadow only reloads on the period wrap
    // so a brightness write never truncates or stretches the current period.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            duty    <= DUTY_FULL;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (period_end) begin
                duty <= bright_reg;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Blink phase. A BLINK_PERIOD write restarts the phase (lit) and wins
    // over a coincident period_end.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_blink_period || (blink_period == 16'd0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (period_end) begin
            if (blink_cnt == (blink_period - 16'd1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for unlisted addresses or unused upper bits.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:         rd_mux[WIDTH-1:0]    = data_reg;
            ADDR_BRIGHT:       rd_mux[PWM_BITS-1:0] = bright_reg;
            ADDR_BLINK:        rd_mux[WIDTH-1:0]    = blink_reg;
            ADDR_BLINK_PERIOD: rd_mux[15:0]         = blink_period;
            default:           rd_mux               = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= '0;
        end else begin
            readdata <= rd_mux;
            out_port <= data_reg & {WIDTH{pwm_on}} & (~blink_reg | {WIDTH{blink_phase}});
        end
    end

endmodule

// File: tb/tb_de1_soc_demo_leds_pwm.sv
// -----------------------------------------------------------------------------
// tb_de1_soc_demo_leds_pwm
//
// Self-checking bench for de1_soc_demo_leds_pwm with PRESCALE=2, PWM_BITS=4
// (PWM period 32 clk). Expected values are queued when stimulus is applied
// and compared when the DUT output becomes valid.
// -----------------------------------------------------------------------------
module tb_de1_soc_demo_leds_pwm;

    localparam int WIDTH    = 10;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int PERIOD   = PRESCALE * (1 << PWM_BITS);   // 32 clk
    localparam logic [31:0] BRIGHT_RST = (1 << PWM_BITS) - 1;

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int unsigned      checks;
    int unsigned      failures;
    logic [31:0]      exp_q[$];

    logic             mon_bit1;
    int unsigned      bit1_drops;

    de1_soc_demo_leds_pwm #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_bit1 && !out_port[1]) bit1_drops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pops the oldest expectation and compares it against the observed value.
    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        exp = (exp_q.size() == 0) ? 32'hxxxx_xxxx : exp_q.pop_front();
        check(tag, got, exp);
    endtask

    // All bus tasks start and end at a falling clock edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        exp_q.push_back(exp);
        @(negedge clk);
        sb_check(tag, readdata);
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (out_port[0]) cnt++;
        end
    endtask

    // Counts consecutive falling-edge samples of bit0 equal to lvl.
    task automatic run_len(input logic lvl, input int maxc, output int len);
        len = 0;
        while (out_port[0] == lvl && len < maxc) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_level(input string tag, input logic lvl, input int maxc);
        int n;
        n = 0;
        while (out_port[0] != lvl && n < maxc) begin
            n++;
            @(negedge clk);
        end
        check(tag, {31'd0, out_port[0]}, {31'd0, lvl});
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int len;
        logic t;

        checks     = 0;
        failures   = 0;
        mon_bit1   = 1'b0;
        bit1_drops = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // ---------------- reset / defaults ----------------
        repeat (3) @(negedge clk);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read("rd_bright_rst", 3'd1, BRIGHT_RST);
        bus_read("rd_bperiod_rst", 3'd5, 32'd0);
        bus_read("rd_blink_rst", 3'd4, 32'd0);

        bus_write(3'd0, 32'h3FF);
        check("data_lat_edge1", 32'(out_port), 32'd0);
        @(negedge clk);
        check("data_lat_edge2", 32'(out_port), 32'h3FF);
        bus_read("rd_data_3ff", 3'd0, 32'h3FF);

        // ---------------- set / clear ----------------
        bus_write(3'd0, 32'h005);
        bus_write(3'd2, 32'h030);
        bus_read("rd_outset", 3'd0, 32'h035);
        bus_write(3'd3, 32'h001);
        bus_read("rd_outclear", 3'd0, 32'h034);
        bus_read("rd_addr2", 3'd2, 32'd0);
        bus_read("rd_addr3", 3'd3, 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read("rd_addr6", 3'd6, 32'd0);
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_read("rd_data_trunc", 3'd0, 32'h3FF);
        bus_write(3'd1, 32'hFFFF_FF0A);
        bus_read("rd_bright_trunc", 3'd1, 32'h00A);

        // ---------------- PWM duty ----------------
        bus_write(3'd0, 32'h001);
        bus_write(3'd1, 32'd4);
        repeat (2 * PERIOD) @(negedge clk);
        exp_q.push_back(3 * 8);
        count_high(3 * PERIOD, cnt);
        sb_check("pwm_duty4", cnt);

        bus_write(3'd1, 32'd0);
        repeat (2 * PERIOD) @(negedge clk);
        exp_q.push_back(0);
        count_high(2 * PERIOD, cnt);
        sb_check("pwm_duty0", cnt);

        bus_write(3'd1, 32'd15);
        repeat (2 * PERIOD) @(negedge clk);
        exp_q.push_back(2 * PERIOD);
        count_high(2 * PERIOD, cnt);
        sb_check("pwm_duty15", cnt);

        // ---------------- glitch-free duty update ----------------
        bus_write(3'd1, 32'd4);
        repeat (2 * PERIOD) @(negedge clk);
        wait_level("glitch_find_low", 1'b0, 2 * PERIOD);
        wait_level("glitch_find_rise", 1'b1, 2 * PERIOD);
        exp_q.push_back(8);
        exp_q.push_back(PERIOD - 8);
        exp_q.push_back(24);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 32'd12;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        run_len(1'b1, 2 * PERIOD, len);
        sb_check("glitch_old_high", len + 1);
        run_len(1'b0, 2 * PERIOD, len);
        sb_check("glitch_low", len);
        run_len(1'b1, 2 * PERIOD, len);
        sb_check("glitch_new_high", len);

        // ---------------- blink ----------------
        bus_write(3'd1, 32'd15);
        bus_write(3'd0, 32'h003);
        bus_write(3'd4, 32'h001);
        bus_write(3'd5, 32'd2);
        repeat (PERIOD + 8) @(negedge clk);
        mon_bit1 = 1'b1;
        t = out_port[0];
        wait_level("blink_first_edge", ~t, 4 * PERIOD);
        exp_q.push_back(2 * PERIOD);
        exp_q.push_back(2 * PERIOD);
        run_len(~t, 4 * PERIOD, len);
        sb_check("blink_half1", len);
        run_len(t, 4 * PERIOD, len);
        sb_check("blink_half2", len);
        mon_bit1 = 1'b0;
        check("blink_bit1_steady", bit1_drops, 32'd0);

        wait_level("blink_find_high", 1'b1, 4 * PERIOD);
        wait_level("blink_find_fall", 1'b0, 4 * PERIOD);
        bus_write(3'd5, 32'd0);
        check("bp0_edge1", {31'd0, out_port[0]}, 32'd0);
        @(negedge clk);
        check("bp0_edge2", {31'd0, out_port[0]}, 32'd1);
        exp_q.push_back(100);
        count_high(100, cnt);
        sb_check("bp0_steady", cnt);

        // ---------------- async reset mid-blink ----------------
        bus_write(3'd5, 32'd2);
        repeat (20) @(negedge clk);
        bus_read("rd_blink_pre", 3'd4, 32'h001);
        check("pre_reset_out", 32'(out_port), 32'h003);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_port), 32'd0);
        check("async_rst_rd", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read("rd_blink_post", 3'd4, 32'd0);
        bus_read("rd_bperiod_post", 3'd5, 32'd0);
        bus_read("rd_data_post", 3'd0, 32'd0);
        bus_read("rd_bright_post", 3'd1, BRIGHT_RST);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
